// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port arbiter bus: WB request, LU valid/ready channel,
// the shared write port, hazard-unit queries and status.
// master = pipeline/LU side that drives requests, slave = the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;

  logic            RegWrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;

  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            pend_rs1;
  logic            pend_rs2;
  logic            pend_rd;

  logic            stall_req;
  logic [CW-1:0]   fifo_cnt;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready,
    input  RegWrite, rd, write_data,
    output chk_rs1, chk_rs2, chk_rd,
    input  pend_rs1, pend_rs2, pend_rd,
    input  stall_req, fifo_cnt
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready,
    output RegWrite, rd, write_data,
    input  chk_rs1, chk_rs2, chk_rd,
    output pend_rs1, pend_rs2, pend_rd,
    output stall_req, fifo_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single register-file write port between the
// writeback stage (absolute priority, never stalled) and a long-latency unit
// whose results wait in a DEPTH-entry in-order FIFO and drain on free cycles.
// Optional feature macro: REGFILE_WR_BYPASS_EN -- when defined, an LU result
// offered while the FIFO is empty and the port is free is written directly
// in the same cycle instead of being enqueued.
//
// LU handshake: lu_valid is held by the LU with stable lu_rd/lu_data until
// the cycle where lu_valid & lu_ready is seen; that cycle is the transfer.
// lu_ready depends only on FIFO occupancy, never on lu_valid or port state.
module regfile_wr_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C    = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT_M1_C = SW'(STARVE_LIMIT - 1);

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic wb_hit;
  logic fifo_empty;
  logic pop;
  logic push;
  logic bypass_take;
  logic lu_ready;

  logic            regwrite_w;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] wdata_w;
  logic            pend_rs1_w, pend_rs2_w, pend_rd_w;

  // x0 writes from WB are treated as no request so the port stays free.
  assign wb_hit     = reset & bus.wb_valid & (bus.wb_rd != 5'd0);
  assign fifo_empty = (cnt_q == '0);
  // Head leaves on every free cycle, including rd==0 entries that write nothing.
  assign pop        = reset & !wb_hit & !fifo_empty;
  assign lu_ready   = reset & (cnt_q < DEPTH_C);

`ifdef REGFILE_WR_BYPASS_EN
  assign bypass_take = reset & fifo_empty & !wb_hit & bus.lu_valid;
`else
  assign bypass_take = 1'b0;
`endif

  // A bypassed result is consumed at the port and must not also be enqueued.
  assign push = bus.lu_valid & lu_ready & !bypass_take;

  // Write-port mux: WB first, then FIFO head, then (optionally) LU bypass.
  always_comb begin
    regwrite_w = 1'b0;
    rd_w       = 5'd0;
    wdata_w    = '0;
    if (wb_hit) begin
      regwrite_w = 1'b1;
      rd_w       = bus.wb_rd;
      wdata_w    = bus.wb_data;
    end else if (pop) begin
      if (rd_mem_q[head_q] != 5'd0) begin
        regwrite_w = 1'b1;
        rd_w       = rd_mem_q[head_q];
        wdata_w    = data_mem_q[head_q];
      end
    end else if (bypass_take) begin
      if (bus.lu_rd != 5'd0) begin
        regwrite_w = 1'b1;
        rd_w       = bus.lu_rd;
        wdata_w    = bus.lu_data;
      end
    end
  end

  // Pending-destination match over live entries; the entry leaving this cycle
  // is already being written, so it no longer counts as pending.
  always_comb begin
    pend_rs1_w = 1'b0;
    pend_rs2_w = 1'b0;
    pend_rd_w  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt_q) && !((k == 0) && pop)) begin
        if ((bus.chk_rs1 != 5'd0) && (rd_mem_q[head_q + PW'(k)] == bus.chk_rs1)) pend_rs1_w = 1'b1;
        if ((bus.chk_rs2 != 5'd0) && (rd_mem_q[head_q + PW'(k)] == bus.chk_rs2)) pend_rs2_w = 1'b1;
        if ((bus.chk_rd  != 5'd0) && (rd_mem_q[head_q + PW'(k)] == bus.chk_rd))  pend_rd_w  = 1'b1;
      end
    end
  end

  // Next-state for pointers, occupancy, starvation counter and stall request.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + SW'(1);
    end
    stall_d = ((starve_q == LIMIT_M1_C) && !pop && !fifo_empty) || (stall_q && !pop);
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // FIFO storage; contents are only meaningful below cnt_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[tail_q]   <= bus.lu_rd;
      data_mem_q[tail_q] <= bus.lu_data;
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.RegWrite   = regwrite_w;
  assign bus.rd         = rd_w;
  assign bus.write_data = wdata_w;
  assign bus.pend_rs1   = pend_rs1_w;
  assign bus.pend_rs2   = pend_rs2_w;
  assign bus.pend_rd    = pend_rd_w;
  assign bus.stall_req  = stall_q;
  assign bus.fifo_cnt   = cnt_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_regfile_wr_arbiter;
  localparam int XLEN = 64;
  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] exp_q[$];

  regfile_wr_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  regfile_wr_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = 5'd0; bus.lu_data = '0;
    bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0; bus.chk_rd = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
    tick(); tick();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_we: got %0h expected 0", bus.RegWrite); end
    checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", bus.fifo_cnt); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0h expected 0", bus.stall_req); end
    checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0h expected 0", bus.lu_ready); end
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_ready: got %0h expected 1", bus.lu_ready); end
  endtask

  task automatic test_wb_priority();
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'hAA;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 64'h77;
    #1;
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd5 || bus.write_data !== 64'hAA) begin
      errors++; $display("FAIL prio_wb: got we=%0h rd=%0d d=%0h expected 1 5 aa", bus.RegWrite, bus.rd, bus.write_data); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.fifo_cnt !== 3'd1) begin errors++; $display("FAIL prio_cnt: got %0d expected 1", bus.fifo_cnt); end
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd7 || bus.write_data !== 64'h77) begin
      errors++; $display("FAIL prio_lu: got we=%0h rd=%0d d=%0h expected 1 7 77", bus.RegWrite, bus.rd, bus.write_data); end
    tick();
    checks++; if (bus.fifo_cnt !== 3'd0 || bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL prio_after: got cnt=%0d we=%0h expected 0 0", bus.fifo_cnt, bus.RegWrite); end
  endtask

  task automatic test_fill_full();
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'h1;
    for (int i = 0; i < 4; i++) begin
      bus.lu_valid = 1'b1; bus.lu_rd = 5'(10 + i); bus.lu_data = 64'(256 + i);
      exp_q.push_back(5'(10 + i));
      #1;
      checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %0h expected 1", i, bus.lu_ready); end
      tick();
    end
    bus.lu_rd = 5'd14; bus.lu_data = 64'h999;
    #1;
    checks++; if (bus.fifo_cnt !== 3'd4 || bus.lu_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got cnt=%0d ready=%0h expected 4 0", bus.fifo_cnt, bus.lu_ready); end
    tick();
    checks++; if (bus.fifo_cnt !== 3'd4) begin errors++; $display("FAIL fill_held: got %0d expected 4", bus.fifo_cnt); end
    for (int i = 0; i < 4; i++) begin
      bus.chk_rd = 5'(10 + i);
      #1;
      checks++; if (bus.pend_rd !== 1'b1) begin errors++; $display("FAIL fill_pend_rd%0d: got %0h expected 1", i, bus.pend_rd); end
    end
    bus.chk_rd = 5'd14; bus.chk_rs1 = 5'd11; bus.chk_rs2 = 5'd0;
    #1;
    checks++; if (bus.pend_rd !== 1'b0) begin errors++; $display("FAIL fill_pend_none: got %0h expected 0", bus.pend_rd); end
    checks++; if (bus.pend_rs1 !== 1'b1) begin errors++; $display("FAIL fill_pend_rs1: got %0h expected 1", bus.pend_rs1); end
    checks++; if (bus.pend_rs2 !== 1'b0) begin errors++; $display("FAIL fill_pend_x0: got %0h expected 0", bus.pend_rs2); end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      bus.chk_rd = e;
      #1;
      checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== e) begin
        errors++; $display("FAIL drain%0d: got we=%0h rd=%0d expected 1 %0d", i, bus.RegWrite, bus.rd, e); end
      checks++; if (bus.pend_rd !== 1'b0) begin errors++; $display("FAIL drain_pend%0d: got %0h expected 0", i, bus.pend_rd); end
      tick();
    end
    checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL drain_cnt: got %0d expected 0", bus.fifo_cnt); end
  endtask

  task automatic test_starve();
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 64'h22;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd20; bus.lu_data = 64'h2020;
    tick();
    bus.lu_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_early%0d: got %0h expected 0", k, bus.stall_req); end
      tick();
    end
    #1;
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL starve_c9: got %0h expected 1", bus.stall_req); end
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd2) begin
      errors++; $display("FAIL starve_wb_wins: got we=%0h rd=%0d expected 1 2", bus.RegWrite, bus.rd); end
    tick();
    checks++; if (bus.stall_req !== 1'b1 || bus.fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL starve_hold: got stall=%0h cnt=%0d expected 1 1", bus.stall_req, bus.fifo_cnt); end
    bus.wb_valid = 1'b0;
    #1;
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd20 || bus.write_data !== 64'h2020) begin
      errors++; $display("FAIL starve_pop: got we=%0h rd=%0d d=%0h expected 1 20 2020", bus.RegWrite, bus.rd, bus.write_data); end
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL starve_pop_stall: got %0h expected 1", bus.stall_req); end
    tick();
    checks++; if (bus.stall_req !== 1'b0 || bus.fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL starve_clear: got stall=%0h cnt=%0d expected 0 0", bus.stall_req, bus.fifo_cnt); end
  endtask

  task automatic test_x0();
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'h1;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 64'h33;
    tick();
    bus.lu_rd = 5'd0; bus.lu_data = 64'h99;
    tick();
    bus.lu_valid = 1'b0;
    bus.wb_rd = 5'd0; bus.wb_data = 64'hDEAD;
    bus.chk_rd = 5'd0;
    #1;
    checks++; if (bus.fifo_cnt !== 3'd2) begin errors++; $display("FAIL x0_cnt2: got %0d expected 2", bus.fifo_cnt); end
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd3 || bus.write_data !== 64'h33) begin
      errors++; $display("FAIL x0_wb_ignored: got we=%0h rd=%0d d=%0h expected 1 3 33", bus.RegWrite, bus.rd, bus.write_data); end
    checks++; if (bus.pend_rd !== 1'b0) begin errors++; $display("FAIL x0_pend: got %0h expected 0", bus.pend_rd); end
    tick();
    checks++; if (bus.fifo_cnt !== 3'd1 || bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL x0_entry: got cnt=%0d we=%0h expected 1 0", bus.fifo_cnt, bus.RegWrite); end
    tick();
    checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL x0_popped: got %0d expected 0", bus.fifo_cnt); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    tick();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 64'h55;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd9 || bus.write_data !== 64'h55) begin
      errors++; $display("FAIL byp_same: got we=%0h rd=%0d d=%0h expected 1 9 55", bus.RegWrite, bus.rd, bus.write_data); end
`else
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL byp_same: got %0h expected 0", bus.RegWrite); end
`endif
    tick();
    bus.lu_valid = 1'b0;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    checks++; if (bus.fifo_cnt !== 3'd0 || bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL byp_next: got cnt=%0d we=%0h expected 0 0", bus.fifo_cnt, bus.RegWrite); end
`else
    checks++; if (bus.fifo_cnt !== 3'd1 || bus.RegWrite !== 1'b1 || bus.rd !== 5'd9 || bus.write_data !== 64'h55) begin
      errors++; $display("FAIL byp_next: got cnt=%0d we=%0h rd=%0d d=%0h expected 1 1 9 55", bus.fifo_cnt, bus.RegWrite, bus.rd, bus.write_data); end
`endif
    tick();
    checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL byp_done: got %0d expected 0", bus.fifo_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    tick();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'h1;
    for (int i = 0; i < 3; i++) begin
      bus.lu_valid = 1'b1; bus.lu_rd = 5'(21 + i); bus.lu_data = 64'(i);
      tick();
    end
    bus.lu_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++; if (bus.stall_req !== 1'b1 || bus.fifo_cnt !== 3'd3) begin
      errors++; $display("FAIL mid_pre: got stall=%0h cnt=%0d expected 1 3", bus.stall_req, bus.fifo_cnt); end
    bus.wb_valid = 1'b0;
    bus.chk_rd = 5'd22;
    #1;
    checks++; if (bus.RegWrite !== 1'b1 || bus.rd !== 5'd21) begin
      errors++; $display("FAIL mid_pop: got we=%0h rd=%0d expected 1 21", bus.RegWrite, bus.rd); end
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.fifo_cnt !== 3'd0 || bus.RegWrite !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got cnt=%0d we=%0h stall=%0h expected 0 0 0", bus.fifo_cnt, bus.RegWrite, bus.stall_req); end
    checks++; if (bus.pend_rd !== 1'b0 || bus.lu_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_comb: got pend=%0h ready=%0h expected 0 0", bus.pend_rd, bus.lu_ready); end
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
    checks++; if (bus.fifo_cnt !== 3'd0 || bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL mid_after: got cnt=%0d we=%0h expected 0 0", bus.fifo_cnt, bus.RegWrite); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_wb_priority();
    test_fill_full();
    test_starve();
    test_x0();
    test_bypass();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
